imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the RV32I/RV64I decode path. Accepts one 32-bit instruction word and its PC per handshake, classifies the instruction format, produces the correctly sign-extended XLEN-wide immediate, and computes the PC-relative target for branch, jump and AUIPC instructions. It sits between the instruction-fetch register and the execute stage, with valid/ready flow control on both sides.

---
 rtl/imm_pkg.sv | 39 +++
 rtl/imm_decode.sv | 42 ++++
 rtl/imm_gen_pipe.sv | 116 +++++++++++
 tb/tb_imm_gen_pipe.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - opcodes, format enum and sign-extension helper for the immediate generator
package imm_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int MAX_XLEN = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_t;

    // Replicates value[width-1] into every bit at or above width; callers truncate to their datapath.
    function automatic logic [MAX_XLEN-1:0] sext(input logic [31:0] value, input int width);
        logic [MAX_XLEN-1:0] r;
        logic                sign;
        sign = value[5'(width - 1)];
        r    = {32'b0, value};
        for (int i = 0; i < MAX_XLEN; i++) begin
            if (i >= width) begin
                r[i] = sign;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational format classification and 32-bit immediate assembly
module imm_decode
    import imm_pkg::*;
(
    input  logic [31:0] instr,
    output fmt_t        fmt,
    output logic        illegal,
    output logic [31:0] imm
);

    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        imm     = '0;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                fmt = FMT_I;
                imm = 32'(sext({20'b0, instr[31:20]}, 12));
            end
            OP_STORE: begin
                fmt = FMT_S;
                imm = 32'(sext({20'b0, instr[31:25], instr[11:7]}, 12));
            end
            OP_BRANCH: begin
                fmt = FMT_B;
                imm = 32'(sext({19'b0, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, 13));
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U;
                imm = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt = FMT_J;
                imm = 32'(sext({11'b0, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}, 21));
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - two-stage immediate generator with PC-relative target and valid/ready flow control
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EN_TARGET = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] target_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    fmt_t            dec_fmt;
    logic            dec_illegal;
    logic [31:0]     dec_imm;

    logic            s1_v, s1_illegal, s1_auipc;
    fmt_t            s1_fmt;
    logic [31:0]     s1_imm;
    logic [XLEN-1:0] s1_pc;

    logic            s2_v, s2_illegal;
    fmt_t            s2_fmt;
    logic [XLEN-1:0] s2_imm, s2_target;

    logic            s1_load, s2_load, accept, tgt_sel;
    logic [XLEN-1:0] imm_ext, target_next;

    imm_decode u_decode (
        .instr   (instr_i),
        .fmt     (dec_fmt),
        .illegal (dec_illegal),
        .imm     (dec_imm)
    );

    assign s2_load = !s2_v || ready_i;
    assign s1_load = !s1_v || s2_load;
    assign ready_o = !flush_i && s1_load;
    assign accept  = valid_i && ready_o;

    assign imm_ext = XLEN'(sext(s1_imm, 32));
    assign tgt_sel = (s1_fmt == FMT_B) || (s1_fmt == FMT_J) || s1_auipc;

    generate
        if (EN_TARGET) begin : g_target
            assign target_next = tgt_sel ? (s1_pc + imm_ext) : '0;
        end else begin : g_no_target
            assign target_next = '0;
        end
    endgenerate

    // Empty stages always hold zero data, so outputs read 0 whenever valid_o is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_v       <= 1'b0;
            s1_fmt     <= FMT_NONE;
            s1_illegal <= 1'b0;
            s1_auipc   <= 1'b0;
            s1_imm     <= '0;
            s1_pc      <= '0;
        end else if (flush_i || (s1_load && !accept)) begin
            s1_v       <= 1'b0;
            s1_fmt     <= FMT_NONE;
            s1_illegal <= 1'b0;
            s1_auipc   <= 1'b0;
            s1_imm     <= '0;
            s1_pc      <= '0;
        end else if (accept) begin
            s1_v       <= 1'b1;
            s1_fmt     <= dec_fmt;
            s1_illegal <= dec_illegal;
            s1_auipc   <= (instr_i[6:0] == OP_AUIPC);
            s1_imm     <= dec_imm;
            s1_pc      <= pc_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_v       <= 1'b0;
            s2_fmt     <= FMT_NONE;
            s2_illegal <= 1'b0;
            s2_imm     <= '0;
            s2_target  <= '0;
        end else if (flush_i) begin
            s2_v       <= 1'b0;
            s2_fmt     <= FMT_NONE;
            s2_illegal <= 1'b0;
            s2_imm     <= '0;
            s2_target  <= '0;
        end else if (s2_load) begin
            s2_v       <= s1_v;
            s2_fmt     <= s1_fmt;
            s2_illegal <= s1_illegal;
            s2_imm     <= imm_ext;
            s2_target  <= target_next;
        end
    end

    assign valid_o   = s2_v;
    assign imm_o     = s2_imm;
    assign target_o  = s2_target;
    assign fmt_o     = s2_fmt;
    assign illegal_o = s2_illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;

    logic        clk;
    logic        reset;
    logic        flush_i;
    logic        valid_i;
    logic        ready_i;
    logic [31:0] instr_i;
    logic [63:0] pc64;
    logic [31:0] pc32;

    logic        r32, v32, ill32;
    logic [31:0] imm32, tgt32;
    logic [2:0]  fmt32;
    logic        r64, v64, ill64;
    logic [63:0] imm64, tgt64;
    logic [2:0]  fmt64;

    int tests;
    int fails;

    assign pc32 = pc64[31:0];

    imm_gen_pipe #(.XLEN(32), .EN_TARGET(1'b1)) dut32 (
        .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(r32),
        .instr_i(instr_i), .pc_i(pc32), .valid_o(v32), .ready_i(ready_i),
        .imm_o(imm32), .target_o(tgt32), .fmt_o(fmt32), .illegal_o(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .EN_TARGET(1'b1)) dut64 (
        .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(r64),
        .instr_i(instr_i), .pc_i(pc64), .valid_o(v64), .ready_i(ready_i),
        .imm_o(imm64), .target_o(tgt64), .fmt_o(fmt64), .illegal_o(ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send_wait(input logic [31:0] ins, input logic [63:0] pc, output int lat);
        int guard;
        @(negedge clk);
        flush_i = 1'b0;
        ready_i = 1'b1;
        valid_i = 1'b1;
        instr_i = ins;
        pc64    = pc;
        #1;
        guard = 0;
        while (!r32 && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        instr_i = '0;
        @(negedge clk);
        lat = 1;
        while (!v32 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic fill_two(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        flush_i = 1'b0;
        ready_i = 1'b0;
        valid_i = 1'b1;
        instr_i = a;
        pc64    = '0;
        @(negedge clk);
        instr_i = b;
        @(negedge clk);
        valid_i = 1'b0;
        instr_i = '0;
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        instr_i = '0;
        pc64    = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({v32, imm32, tgt32, fmt32, ill32} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b imm=%h tgt=%h fmt=%0d ill=%b expected all 0", v32, imm32, tgt32, fmt32, ill32);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (r32 !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b expected 1", r32);
        end
    endtask

    task automatic test_addi();
        int lat;
        send_wait(32'hFFF00093, 64'h1000, lat);
        tests++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL addi_latency: got %0d expected 2", lat);
        end
        tests++;
        if (imm32 !== 32'hFFFFFFFF || fmt32 !== 3'd1 || tgt32 !== 32'h0 || ill32 !== 1'b0) begin
            fails++;
            $display("FAIL addi_result: got imm=%h fmt=%0d tgt=%h ill=%b expected FFFFFFFF 1 0 0", imm32, fmt32, tgt32, ill32);
        end
        tests++;
        if (imm64 !== 64'hFFFFFFFFFFFFFFFF) begin
            fails++;
            $display("FAIL addi_imm64: got %h expected FFFFFFFFFFFFFFFF", imm64);
        end
    endtask

    task automatic test_target();
        int lat;
        send_wait(32'hFE000EE3, 64'h1000, lat);
        tests++;
        if (imm32 !== 32'hFFFFFFFC || tgt32 !== 32'h00000FFC || fmt32 !== 3'd3) begin
            fails++;
            $display("FAIL beq: got imm=%h tgt=%h fmt=%0d expected FFFFFFFC 00000FFC 3", imm32, tgt32, fmt32);
        end
        send_wait(32'h008000EF, 64'h1000, lat);
        tests++;
        if (imm32 !== 32'h8 || tgt32 !== 32'h1008 || fmt32 !== 3'd5) begin
            fails++;
            $display("FAIL jal: got imm=%h tgt=%h fmt=%0d expected 8 1008 5", imm32, tgt32, fmt32);
        end
        send_wait(32'h12345017, 64'h1000, lat);
        tests++;
        if (imm32 !== 32'h12345000 || tgt32 !== 32'h12346000 || fmt32 !== 3'd4) begin
            fails++;
            $display("FAIL auipc: got imm=%h tgt=%h fmt=%0d expected 12345000 12346000 4", imm32, tgt32, fmt32);
        end
        send_wait(32'hFE000E23, 64'h1000, lat);
        tests++;
        if (imm32 !== 32'hFFFFFFFC || tgt32 !== 32'h0 || fmt32 !== 3'd2) begin
            fails++;
            $display("FAIL sw: got imm=%h tgt=%h fmt=%0d expected FFFFFFFC 0 2", imm32, tgt32, fmt32);
        end
        send_wait(32'hFFC08067, 64'h1000, lat);
        tests++;
        if (imm32 !== 32'hFFFFFFFC || tgt32 !== 32'h0 || fmt32 !== 3'd1) begin
            fails++;
            $display("FAIL jalr: got imm=%h tgt=%h fmt=%0d expected FFFFFFFC 0 1", imm32, tgt32, fmt32);
        end
    endtask

    task automatic test_xlen64();
        int lat;
        send_wait(32'h800000B7, 64'h1000, lat);
        tests++;
        if (imm64 !== 64'hFFFFFFFF80000000 || tgt64 !== 64'h0 || fmt64 !== 3'd4) begin
            fails++;
            $display("FAIL lui64: got imm=%h tgt=%h fmt=%0d expected FFFFFFFF80000000 0 4", imm64, tgt64, fmt64);
        end
        tests++;
        if (imm32 !== 32'h80000000) begin
            fails++;
            $display("FAIL lui32: got %h expected 80000000", imm32);
        end
        send_wait(32'h0200006F, 64'hFFFFFFFFFFFFFFF0, lat);
        tests++;
        if (imm64 !== 64'h20 || tgt64 !== 64'h10) begin
            fails++;
            $display("FAIL jal_wrap64: got imm=%h tgt=%h expected 20 10", imm64, tgt64);
        end
        tests++;
        if (tgt32 !== 32'h10) begin
            fails++;
            $display("FAIL jal_wrap32: got %h expected 10", tgt32);
        end
    endtask

    task automatic test_illegal();
        int lat;
        send_wait(32'h0000007F, 64'h2000, lat);
        tests++;
        if (ill32 !== 1'b1 || fmt32 !== 3'd0 || imm32 !== 32'h0 || tgt32 !== 32'h0) begin
            fails++;
            $display("FAIL illegal: got ill=%b fmt=%0d imm=%h tgt=%h expected 1 0 0 0", ill32, fmt32, imm32, tgt32);
        end
        send_wait(32'h00500093, 64'h2000, lat);
        tests++;
        if (ill32 !== 1'b0 || fmt32 !== 3'd1 || imm32 !== 32'h5 || lat !== 2) begin
            fails++;
            $display("FAIL after_illegal: got ill=%b fmt=%0d imm=%h lat=%0d expected 0 1 5 2", ill32, fmt32, imm32, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  pat;
        logic        stall_prev;
        logic [31:0] imm_prev;
        int sent, rcv, cnt, cyc;
        pat        = 4'b1001;
        stall_prev = 1'b0;
        imm_prev   = '0;
        sent = 0;
        rcv  = 0;
        cnt  = 0;
        cyc  = 0;
        while (rcv < 8 && cyc < 200) begin
            @(negedge clk);
            flush_i = 1'b0;
            ready_i = pat[cyc % 4];
            pc64    = 64'h3000;
            if (sent < 8) begin
                valid_i = 1'b1;
                instr_i = (32'(sent + 1) << 20) | 32'h00000093;
            end else begin
                valid_i = 1'b0;
                instr_i = '0;
            end
            #1;
            tests++;
            if (r32 !== !(cnt == 2 && !ready_i)) begin
                fails++;
                $display("FAIL b2b_ready cyc %0d: got %b expected %b", cyc, r32, !(cnt == 2 && !ready_i));
            end
            if (stall_prev) begin
                tests++;
                if (v32 !== 1'b1 || imm32 !== imm_prev) begin
                    fails++;
                    $display("FAIL b2b_stall cyc %0d: got v=%b imm=%h expected 1 %h", cyc, v32, imm32, imm_prev);
                end
            end
            if (v32 && ready_i) begin
                tests++;
                if (imm32 !== 32'(rcv + 1)) begin
                    fails++;
                    $display("FAIL b2b_order item %0d: got %h expected %h", rcv, imm32, 32'(rcv + 1));
                end
                rcv++;
                cnt--;
            end
            if (valid_i && r32) begin
                sent++;
                cnt++;
            end
            stall_prev = v32 && !ready_i;
            imm_prev   = imm32;
            cyc++;
        end
        tests++;
        if (rcv !== 8) begin
            fails++;
            $display("FAIL b2b_count: got %0d expected 8", rcv);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (v32 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_extra: got valid_o %b expected 0", v32);
        end
    endtask

    task automatic test_flush();
        int lat;
        fill_two(32'h00A00093, 32'h00B00093);
        tests++;
        if (r32 !== 1'b0 || v32 !== 1'b1 || imm32 !== 32'hA) begin
            fails++;
            $display("FAIL flush_full: got ready=%b v=%b imm=%h expected 0 1 a", r32, v32, imm32);
        end
        flush_i = 1'b1;
        ready_i = 1'b1;
        valid_i = 1'b1;
        instr_i = 32'h00C00093;
        #1;
        tests++;
        if (r32 !== 1'b0) begin
            fails++;
            $display("FAIL flush_ready: got %b expected 0", r32);
        end
        @(negedge clk);
        flush_i = 1'b0;
        valid_i = 1'b0;
        instr_i = '0;
        #1;
        tests++;
        if ({v32, imm32, tgt32, fmt32, ill32} !== '0) begin
            fails++;
            $display("FAIL flush_clear: got v=%b imm=%h tgt=%h fmt=%0d ill=%b expected all 0", v32, imm32, tgt32, fmt32, ill32);
        end
        @(negedge clk);
        tests++;
        if (v32 !== 1'b0) begin
            fails++;
            $display("FAIL flush_dropped: got valid_o %b expected 0", v32);
        end
        send_wait(32'h00700093, 64'h0, lat);
        tests++;
        if (lat !== 2 || imm32 !== 32'h7) begin
            fails++;
            $display("FAIL flush_after: got lat=%0d imm=%h expected 2 7", lat, imm32);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        fill_two(32'h0000006F, 32'h00D00093);
        #1;
        reset = 1'b0;
        #1;
        tests++;
        if ({v32, imm32, tgt32, fmt32, ill32} !== '0 || v64 !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: got v=%b imm=%h tgt=%h fmt=%0d ill=%b expected all 0", v32, imm32, tgt32, fmt32, ill32);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (r32 !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_ready: got %b expected 1", r32);
        end
        send_wait(32'h00E00093, 64'h0, lat);
        tests++;
        if (lat !== 2 || imm32 !== 32'hE) begin
            fails++;
            $display("FAIL reset_mid_after: got lat=%0d imm=%h expected 2 e", lat, imm32);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_addi();
        test_target();
        test_xlen64();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
